// File: rtl/rob_multiport_if.sv
// rob_multiport_if: allocation, operand lookup, completion, commit and recovery
// signals between the pipeline and the reorder buffer.
interface rob_multiport_if #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned NUM_CP = 2
);
  localparam int unsigned TAG_W = $clog2(DEPTH) + 1;

  // Allocation (decode/rename)
  logic                     alloc_valid_i;
  logic [DEST_W-1:0]        alloc_dest_i;
  logic                     alloc_ready_o;
  logic [TAG_W-1:0]         alloc_tag_o;

  // Operand lookup (rename)
  logic [TAG_W-1:0]         src1_tag_i;
  logic [TAG_W-1:0]         src2_tag_i;
  logic                     src1_ready_o;
  logic [DATA_W-1:0]        src1_data_o;
  logic                     src2_ready_o;
  logic [DATA_W-1:0]        src2_data_o;

  // Completion (execute)
  logic [NUM_CP-1:0]        cp_valid_i;
  logic [NUM_CP*TAG_W-1:0]  cp_tag_i;
  logic [NUM_CP*DATA_W-1:0] cp_data_i;
  logic [NUM_CP-1:0]        cp_exc_i;

  // Commit (regfile)
  logic                     commit_valid_o;
  logic                     commit_ready_i;
  logic [TAG_W-1:0]         commit_tag_o;
  logic [DEST_W-1:0]        commit_dest_o;
  logic [DATA_W-1:0]        commit_data_o;
  logic                     commit_exc_o;

  // Recovery and status
  logic                     squash_valid_i;
  logic [TAG_W-1:0]         squash_tag_i;
  logic                     flush_i;
  logic [TAG_W-1:0]         count_o;

  modport master (
    output alloc_valid_i, alloc_dest_i, src1_tag_i, src2_tag_i,
    output cp_valid_i, cp_tag_i, cp_data_i, cp_exc_i,
    output commit_ready_i, squash_valid_i, squash_tag_i, flush_i,
    input  alloc_ready_o, alloc_tag_o, src1_ready_o, src1_data_o, src2_ready_o, src2_data_o,
    input  commit_valid_o, commit_tag_o, commit_dest_o, commit_data_o, commit_exc_o, count_o
  );

  modport slave (
    input  alloc_valid_i, alloc_dest_i, src1_tag_i, src2_tag_i,
    input  cp_valid_i, cp_tag_i, cp_data_i, cp_exc_i,
    input  commit_ready_i, squash_valid_i, squash_tag_i, flush_i,
    output alloc_ready_o, alloc_tag_o, src1_ready_o, src1_data_o, src2_ready_o, src2_data_o,
    output commit_valid_o, commit_tag_o, commit_dest_o, commit_data_o, commit_exc_o, count_o
  );
endinterface

// File: rtl/rob_multiport.sv
// rob_multiport: DEPTH-entry reorder buffer with NUM_CP completion ports, operand
// lookup with same-cycle completion bypass, in-order commit, squash-to-tag and flush.
// Tags are 1-based (tag = slot + 1); tag 0 means "not in the ROB".
module rob_multiport #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned NUM_CP = 2,
  localparam int unsigned TAG_W = $clog2(DEPTH) + 1
) (
  input logic            clk_i,
  input logic            reset_i,
  rob_multiport_if.slave bus
);
  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  exc_q, exc_d;
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DEST_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [TAG_W-1:0]  count_q, count_d;

  logic              alloc_ready, alloc_fire;
  logic              commit_valid, commit_fire;
  logic [PTR_W-1:0]  sq_slot, sq_age;
  logic [PTR_W-1:0]  cp_age, slot_age;

  // Unpacked completion ports
  logic [TAG_W-1:0]  cp_tag  [NUM_CP];
  logic [DATA_W-1:0] cp_data [NUM_CP];
  logic [PTR_W-1:0]  cp_slot [NUM_CP];
  logic [NUM_CP-1:0] cp_hit;

  // Operand lookup
  logic [TAG_W-1:0]  src_tag   [2];
  logic [PTR_W-1:0]  src_slot  [2];
  logic [DATA_W-1:0] src_data  [2];
  logic [1:0]        src_ready;

  // A tag names a live entry when it is non-zero, in range and its slot is valid.
  function automatic logic tag_live(input logic [TAG_W-1:0] tag, input logic [DEPTH-1:0] valid);
    logic [PTR_W-1:0] slot;
    slot = PTR_W'(tag - TAG_W'(1));
    return (tag != '0) && (tag <= DEPTH_TAG) && valid[slot];
  endfunction

  assign alloc_ready  = (count_q < DEPTH_TAG) & ~bus.squash_valid_i & ~bus.flush_i;
  assign alloc_fire   = bus.alloc_valid_i & alloc_ready;
  assign commit_valid = valid_q[head_q] & done_q[head_q] & ~bus.flush_i;
  assign commit_fire  = commit_valid & bus.commit_ready_i;

  // Age is distance from head; entries older than the squash point survive.
  assign sq_slot = PTR_W'(bus.squash_tag_i - TAG_W'(1));
  assign sq_age  = sq_slot - head_q;

  assign bus.alloc_ready_o  = alloc_ready;
  assign bus.alloc_tag_o    = TAG_W'(tail_q) + TAG_W'(1);
  assign bus.commit_valid_o = commit_valid;
  assign bus.commit_tag_o   = TAG_W'(head_q) + TAG_W'(1);
  assign bus.commit_dest_o  = dest_q[head_q];
  assign bus.commit_data_o  = data_q[head_q];
  assign bus.commit_exc_o   = exc_q[head_q];
  assign bus.count_o        = count_q;
  assign bus.src1_ready_o   = src_ready[0];
  assign bus.src1_data_o    = src_data[0];
  assign bus.src2_ready_o   = src_ready[1];
  assign bus.src2_data_o    = src_data[1];

  // Split the flattened completion buses and flag strobes that land on a live slot.
  always_comb begin
    for (int p = 0; p < NUM_CP; p++) begin
      cp_tag[p]  = bus.cp_tag_i[p*TAG_W +: TAG_W];
      cp_data[p] = bus.cp_data_i[p*DATA_W +: DATA_W];
      cp_slot[p] = PTR_W'(cp_tag[p] - TAG_W'(1));
      cp_hit[p]  = bus.cp_valid_i[p] & tag_live(cp_tag[p], valid_q);
    end
  end

  // Operand lookup: stored result, overridden by a same-cycle completion (last port wins).
  always_comb begin
    src_tag[0] = bus.src1_tag_i;
    src_tag[1] = bus.src2_tag_i;
    for (int s = 0; s < 2; s++) begin
      src_slot[s]  = PTR_W'(src_tag[s] - TAG_W'(1));
      src_ready[s] = 1'b0;
      src_data[s]  = '0;
      if (src_tag[s] != '0 && src_tag[s] <= DEPTH_TAG) begin
        src_ready[s] = valid_q[src_slot[s]] & done_q[src_slot[s]];
        src_data[s]  = data_q[src_slot[s]];
        if (valid_q[src_slot[s]]) begin
          for (int p = 0; p < NUM_CP; p++) begin
            if (bus.cp_valid_i[p] && cp_tag[p] == src_tag[s]) begin
              src_ready[s] = 1'b1;
              src_data[s]  = cp_data[p];
            end
          end
        end
      end
    end
  end

  // Next state: completions, allocation, commit, then squash and flush overrides.
  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    exc_d    = exc_q;
    dest_d   = dest_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cp_age   = '0;
    slot_age = '0;

    // Later ports overwrite earlier ones; completions to squashed slots are dropped.
    for (int p = 0; p < NUM_CP; p++) begin
      cp_age = cp_slot[p] - head_q;
      if (cp_hit[p] && (!bus.squash_valid_i || cp_age <= sq_age)) begin
        done_d[cp_slot[p]] = 1'b1;
        exc_d[cp_slot[p]]  = bus.cp_exc_i[p];
        data_d[cp_slot[p]] = cp_data[p];
      end
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      exc_d[tail_q]   = 1'b0;
      dest_d[tail_q]  = bus.alloc_dest_i;
      data_d[tail_q]  = '0;
    end

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    if (bus.squash_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_age = PTR_W'(i) - head_q;
        if (slot_age > sq_age) valid_d[i] = 1'b0;
      end
      tail_d  = sq_slot + PTR_W'(1);
      count_d = TAG_W'(sq_age) + TAG_W'(1) - TAG_W'(commit_fire);
    end else begin
      if (alloc_fire) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit_fire);
    end

    // Flush returns everything to the reset image.
    if (bus.flush_i) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_d[i] = '0;
        data_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed scenarios plus a randomized run against a queue-based
// reference model of the reorder buffer (DEPTH=8, two completion ports).
module tb_rob_multiport;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned NUM_CP = 2;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          done;
    bit          exc;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: live entries oldest first, plus the next tag to hand out.
  ent_t mq[$];
  int   m_next;

  rob_multiport_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W), .NUM_CP(NUM_CP)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W), .NUM_CP(NUM_CP)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_idle();
    bus.alloc_valid_i  = 1'b0;
    bus.alloc_dest_i   = '0;
    bus.src1_tag_i     = '0;
    bus.src2_tag_i     = '0;
    bus.cp_valid_i     = '0;
    bus.cp_tag_i       = '0;
    bus.cp_data_i      = '0;
    bus.cp_exc_i       = '0;
    bus.commit_ready_i = 1'b0;
    bus.squash_valid_i = 1'b0;
    bus.squash_tag_i   = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int find_idx(input int tag);
    for (int k = 0; k < mq.size(); k++) if (mq[k].tag == tag) return k;
    return -1;
  endfunction

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    bus.src1_tag_i = 4'd1;
    cycle();
    n_vec++; if (bus.count_o !== 4'd0)
      begin n_err++; $display("FAIL reset count_o: got %0d want 0", bus.count_o); end
    n_vec++; if (bus.alloc_ready_o !== 1'b1)
      begin n_err++; $display("FAIL reset alloc_ready_o: got %b want 1", bus.alloc_ready_o); end
    n_vec++; if (bus.alloc_tag_o !== 4'd1)
      begin n_err++; $display("FAIL reset alloc_tag_o: got %0d want 1", bus.alloc_tag_o); end
    n_vec++; if (bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL reset commit_valid_o: got %b want 0", bus.commit_valid_o); end
    n_vec++; if (bus.src1_ready_o !== 1'b0 || bus.src1_data_o !== 64'd0)
      begin n_err++; $display("FAIL reset src1: got %b/%0h want 0/0", bus.src1_ready_o,
                              bus.src1_data_o); end
    n_vec++; if (bus.commit_data_o !== 64'd0)
      begin n_err++; $display("FAIL reset commit_data_o: got %0h want 0", bus.commit_data_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.src1_tag_i = '0;
    cycle();
  endtask

  task automatic test_alloc_four();
    for (int i = 1; i <= 4; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_dest_i  = 5'(i);
      #1;
      n_vec++; if (bus.alloc_tag_o !== 4'(i))
        begin n_err++; $display("FAIL alloc tag: got %0d want %0d", bus.alloc_tag_o, i); end
      cycle();
    end
    bus.alloc_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.count_o !== 4'd4)
      begin n_err++; $display("FAIL alloc count_o: got %0d want 4", bus.count_o); end
    n_vec++; if (bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL alloc commit_valid_o: got %b want 0", bus.commit_valid_o); end
  endtask

  task automatic test_complete_commit();
    bus.cp_valid_i     = 2'b11;
    bus.cp_tag_i       = {4'd1, 4'd2};
    bus.cp_data_i      = {64'h11, 64'h22};
    bus.commit_ready_i = 1'b1;
    #1;
    n_vec++; if (bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL cc early commit_valid: got %b want 0", bus.commit_valid_o); end
    cycle();
    bus.cp_valid_i = '0;
    #1;
    n_vec++; if (bus.commit_valid_o !== 1'b1 || bus.commit_tag_o !== 4'd1 ||
                 bus.commit_data_o !== 64'h11 || bus.commit_dest_o !== 5'd1)
      begin n_err++; $display("FAIL cc commit1: got v%b t%0d d%0h r%0d want v1 t1 d11 r1",
        bus.commit_valid_o, bus.commit_tag_o, bus.commit_data_o, bus.commit_dest_o); end
    n_vec++; if (bus.count_o !== 4'd4)
      begin n_err++; $display("FAIL cc count before: got %0d want 4", bus.count_o); end
    cycle();
    n_vec++; if (bus.commit_valid_o !== 1'b1 || bus.commit_tag_o !== 4'd2 ||
                 bus.commit_data_o !== 64'h22)
      begin n_err++; $display("FAIL cc commit2: got v%b t%0d d%0h want v1 t2 d22",
        bus.commit_valid_o, bus.commit_tag_o, bus.commit_data_o); end
    n_vec++; if (bus.count_o !== 4'd3)
      begin n_err++; $display("FAIL cc count mid: got %0d want 3", bus.count_o); end
    cycle();
    n_vec++; if (bus.count_o !== 4'd2 || bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL cc count after: got %0d/v%b want 2/v0", bus.count_o,
                              bus.commit_valid_o); end
    bus.commit_ready_i = 1'b0;
  endtask

  task automatic test_bypass();
    bus.src1_tag_i = 4'd3;
    bus.src2_tag_i = 4'd4;
    bus.cp_valid_i = 2'b10;
    bus.cp_tag_i   = {4'd3, 4'd0};
    bus.cp_data_i  = {64'hAB, 64'h0};
    #1;
    n_vec++; if (bus.src1_ready_o !== 1'b1 || bus.src1_data_o !== 64'hAB)
      begin n_err++; $display("FAIL bypass port1: got %b/%0h want 1/ab", bus.src1_ready_o,
                              bus.src1_data_o); end
    n_vec++; if (bus.src2_ready_o !== 1'b0)
      begin n_err++; $display("FAIL bypass src2 ready: got %b want 0", bus.src2_ready_o); end
    bus.cp_valid_i = 2'b11;
    bus.cp_tag_i   = {4'd3, 4'd3};
    bus.cp_data_i  = {64'hAB, 64'hCD};
    #1;
    n_vec++; if (bus.src1_ready_o !== 1'b1 || bus.src1_data_o !== 64'hAB)
      begin n_err++; $display("FAIL bypass both ports: got %b/%0h want 1/ab", bus.src1_ready_o,
                              bus.src1_data_o); end
    cycle();
    bus.cp_valid_i = '0;
    #1;
    n_vec++; if (bus.src1_ready_o !== 1'b1 || bus.src1_data_o !== 64'hAB)
      begin n_err++; $display("FAIL stored port priority: got %b/%0h want 1/ab",
                              bus.src1_ready_o, bus.src1_data_o); end
    n_vec++; if (bus.commit_valid_o !== 1'b1 || bus.commit_tag_o !== 4'd3)
      begin n_err++; $display("FAIL bypass commit head: got v%b t%0d want v1 t3",
                              bus.commit_valid_o, bus.commit_tag_o); end
  endtask

  task automatic test_flush();
    for (int i = 5; i <= 7; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_dest_i  = 5'(i);
      #1;
      n_vec++; if (bus.alloc_tag_o !== 4'(i))
        begin n_err++; $display("FAIL flush prefill tag: got %0d want %0d", bus.alloc_tag_o, i); end
      cycle();
    end
    bus.flush_i = 1'b1;
    #1;
    n_vec++; if (bus.count_o !== 4'd5)
      begin n_err++; $display("FAIL flush live count: got %0d want 5", bus.count_o); end
    n_vec++; if (bus.alloc_ready_o !== 1'b0 || bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL flush gating: got ar%b cv%b want 0 0", bus.alloc_ready_o,
                              bus.commit_valid_o); end
    cycle();
    set_idle();
    bus.src1_tag_i = 4'd3;
    #1;
    n_vec++; if (bus.count_o !== 4'd0 || bus.alloc_tag_o !== 4'd1 || bus.commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL flush result: got c%0d t%0d v%b want c0 t1 v0",
        bus.count_o, bus.alloc_tag_o, bus.commit_valid_o); end
    n_vec++; if (bus.src1_ready_o !== 1'b0)
      begin n_err++; $display("FAIL flush src1: got %b want 0", bus.src1_ready_o); end
    bus.src1_tag_i = '0;
  endtask

  task automatic test_full_wrap();
    for (int i = 1; i <= 8; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_dest_i  = 5'(i);
      #1;
      n_vec++; if (bus.alloc_ready_o !== 1'b1 || bus.alloc_tag_o !== 4'(i))
        begin n_err++; $display("FAIL fill step: got r%b t%0d want r1 t%0d", bus.alloc_ready_o,
                                bus.alloc_tag_o, i); end
      cycle();
    end
    bus.alloc_dest_i = 5'd31;
    #1;
    n_vec++; if (bus.count_o !== 4'd8 || bus.alloc_ready_o !== 1'b0 || bus.alloc_tag_o !== 4'd1)
      begin n_err++; $display("FAIL full state: got c%0d r%b t%0d want c8 r0 t1", bus.count_o,
                              bus.alloc_ready_o, bus.alloc_tag_o); end
    cycle();
    bus.cp_valid_i = 2'b01;
    bus.cp_tag_i   = {4'd0, 4'd1};
    bus.cp_data_i  = {64'h0, 64'h5A};
    cycle();
    bus.cp_valid_i = '0;
    #1;
    n_vec++; if (bus.commit_valid_o !== 1'b1 || bus.commit_dest_o !== 5'd1 ||
                 bus.commit_data_o !== 64'h5A || bus.count_o !== 4'd8)
      begin n_err++; $display("FAIL full no overwrite: got v%b r%0d d%0h c%0d want v1 r1 d5a c8",
        bus.commit_valid_o, bus.commit_dest_o, bus.commit_data_o, bus.count_o); end
    bus.commit_ready_i = 1'b1;
    #1;
    n_vec++; if (bus.alloc_ready_o !== 1'b0)
      begin n_err++; $display("FAIL full commit no bypass: got %b want 0", bus.alloc_ready_o); end
    cycle();
    bus.commit_ready_i = 1'b0;
    bus.alloc_dest_i   = 5'd9;
    #1;
    n_vec++; if (bus.count_o !== 4'd7 || bus.alloc_ready_o !== 1'b1 || bus.alloc_tag_o !== 4'd1)
      begin n_err++; $display("FAIL after commit: got c%0d r%b t%0d want c7 r1 t1", bus.count_o,
                              bus.alloc_ready_o, bus.alloc_tag_o); end
    cycle();
    bus.alloc_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.count_o !== 4'd8 || bus.alloc_ready_o !== 1'b0 || bus.commit_tag_o !== 4'd2)
      begin n_err++; $display("FAIL wrap refill: got c%0d r%b h%0d want c8 r0 h2", bus.count_o,
                              bus.alloc_ready_o, bus.commit_tag_o); end
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
  endtask

  task automatic test_squash();
    for (int i = 1; i <= 6; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_dest_i  = 5'(i);
      cycle();
    end
    bus.alloc_valid_i  = 1'b0;
    bus.squash_valid_i = 1'b1;
    bus.squash_tag_i   = 4'd3;
    #1;
    n_vec++; if (bus.alloc_ready_o !== 1'b0 || bus.count_o !== 4'd6)
      begin n_err++; $display("FAIL squash pre: got r%b c%0d want r0 c6", bus.alloc_ready_o,
                              bus.count_o); end
    cycle();
    bus.squash_valid_i = 1'b0;
    bus.cp_valid_i     = 2'b01;
    bus.cp_tag_i       = {4'd0, 4'd5};
    bus.cp_data_i      = {64'h0, 64'h55};
    bus.src1_tag_i     = 4'd5;
    #1;
    n_vec++; if (bus.count_o !== 4'd3 || bus.alloc_tag_o !== 4'd4)
      begin n_err++; $display("FAIL squash result: got c%0d t%0d want c3 t4", bus.count_o,
                              bus.alloc_tag_o); end
    n_vec++; if (bus.src1_ready_o !== 1'b0)
      begin n_err++; $display("FAIL stale bypass: got %b want 0", bus.src1_ready_o); end
    cycle();
    bus.cp_valid_i    = '0;
    bus.alloc_valid_i = 1'b1;
    bus.alloc_dest_i  = 5'd20;
    cycle();
    bus.alloc_dest_i  = 5'd21;
    #1;
    n_vec++; if (bus.alloc_tag_o !== 4'd5)
      begin n_err++; $display("FAIL realloc tag: got %0d want 5", bus.alloc_tag_o); end
    cycle();
    bus.alloc_valid_i = 1'b0;
    bus.src2_tag_i    = 4'd4;
    #1;
    n_vec++; if (bus.src1_ready_o !== 1'b0 || bus.src2_ready_o !== 1'b0 || bus.count_o !== 4'd5)
      begin n_err++; $display("FAIL realloc not done: got %b %b c%0d want 0 0 c5",
        bus.src1_ready_o, bus.src2_ready_o, bus.count_o); end
    set_idle();
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_dest_i  = 5'(i);
      cycle();
    end
    bus.alloc_valid_i = 1'b0;
    bus.cp_valid_i    = 2'b01;
    bus.cp_tag_i      = {4'd0, 4'd1};
    bus.cp_data_i     = {64'h0, 64'h77};
    cycle();
    bus.cp_valid_i = '0;
    n_vec++; if (bus.count_o !== 4'd3 || bus.commit_valid_o !== 1'b1)
      begin n_err++; $display("FAIL pre-reset state: got c%0d v%b want c3 v1", bus.count_o,
                              bus.commit_valid_o); end
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.count_o !== 4'd0 || bus.alloc_tag_o !== 4'd1 ||
                 bus.commit_valid_o !== 1'b0 || bus.alloc_ready_o !== 1'b1)
      begin n_err++; $display("FAIL async reset: got c%0d t%0d v%b r%b want c0 t1 v0 r1",
        bus.count_o, bus.alloc_tag_o, bus.commit_valid_o, bus.alloc_ready_o); end
    #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    bit          flush, squash, cr, av, cf, af, e_cv, e_rdy;
    int          sq_tag, k, kq;
    logic [4:0]  adest;
    bit          cpv [2];
    bit          cpx [2];
    int          cpt [2];
    logic [63:0] cpd [2];
    int          st  [2];
    logic        got_rdy;
    logic [63:0] got_dat, e_dat;
    ent_t        ent;
    mq.delete();
    m_next = 1;
    for (int c = 0; c < 1500; c++) begin
      flush  = ($urandom_range(0, 63) == 0);
      squash = (mq.size() > 0) && ($urandom_range(0, 11) == 0);
      sq_tag = squash ? mq[$urandom_range(0, mq.size() - 1)].tag : int'($urandom_range(0, 8));
      av     = ($urandom_range(0, 9) < 6);
      adest  = 5'($urandom);
      cr     = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < 2; p++) begin
        cpv[p] = $urandom_range(0, 1) == 1;
        cpx[p] = ($urandom_range(0, 7) == 0);
        cpd[p] = {$urandom, $urandom};
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          cpt[p] = mq[$urandom_range(0, mq.size() - 1)].tag;
        else
          cpt[p] = int'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 7) == 0) cpt[1] = cpt[0];
      for (int s = 0; s < 2; s++)
        st[s] = ($urandom_range(0, 9) < 4) ? cpt[$urandom_range(0, 1)] : int'($urandom_range(0, 8));

      bus.flush_i        = flush;
      bus.squash_valid_i = squash;
      bus.squash_tag_i   = 4'(sq_tag);
      bus.alloc_valid_i  = av;
      bus.alloc_dest_i   = adest;
      bus.commit_ready_i = cr;
      bus.cp_valid_i     = {cpv[1], cpv[0]};
      bus.cp_exc_i       = {cpx[1], cpx[0]};
      bus.cp_tag_i       = {4'(cpt[1]), 4'(cpt[0])};
      bus.cp_data_i      = {cpd[1], cpd[0]};
      bus.src1_tag_i     = 4'(st[0]);
      bus.src2_tag_i     = 4'(st[1]);
      #1;

      e_cv = (mq.size() > 0) && mq[0].done && !flush;
      n_vec++; if (bus.count_o !== 4'(mq.size()))
        begin n_err++; $display("FAIL rnd count c%0d: got %0d want %0d", c, bus.count_o,
                                mq.size()); end
      n_vec++; if (bus.alloc_ready_o !== (mq.size() < 8 && !squash && !flush))
        begin n_err++; $display("FAIL rnd alloc_ready c%0d: got %b", c, bus.alloc_ready_o); end
      n_vec++; if (bus.alloc_tag_o !== 4'(m_next))
        begin n_err++; $display("FAIL rnd alloc_tag c%0d: got %0d want %0d", c, bus.alloc_tag_o,
                                m_next); end
      n_vec++; if (bus.commit_valid_o !== e_cv)
        begin n_err++; $display("FAIL rnd commit_valid c%0d: got %b want %b", c,
                                bus.commit_valid_o, e_cv); end
      if (e_cv) begin
        n_vec++; if (bus.commit_tag_o !== 4'(mq[0].tag) || bus.commit_dest_o !== mq[0].dest ||
                     bus.commit_data_o !== mq[0].data || bus.commit_exc_o !== mq[0].exc)
          begin n_err++; $display("FAIL rnd commit c%0d: got t%0d r%0d d%0h x%b want t%0d r%0d d%0h x%b",
            c, bus.commit_tag_o, bus.commit_dest_o, bus.commit_data_o, bus.commit_exc_o,
            mq[0].tag, mq[0].dest, mq[0].data, mq[0].exc); end
      end
      for (int s = 0; s < 2; s++) begin
        e_rdy = 1'b0;
        e_dat = '0;
        k = find_idx(st[s]);
        if (st[s] != 0 && k >= 0) begin
          if (mq[k].done) begin e_rdy = 1'b1; e_dat = mq[k].data; end
          for (int p = 0; p < 2; p++)
            if (cpv[p] && cpt[p] == st[s]) begin e_rdy = 1'b1; e_dat = cpd[p]; end
        end
        got_rdy = (s == 0) ? bus.src1_ready_o : bus.src2_ready_o;
        got_dat = (s == 0) ? bus.src1_data_o : bus.src2_data_o;
        n_vec++; if (got_rdy !== e_rdy)
          begin n_err++; $display("FAIL rnd src%0d ready c%0d tag %0d: got %b want %b", s + 1, c,
                                  st[s], got_rdy, e_rdy); end
        if (e_rdy || st[s] == 0) begin
          n_vec++; if (got_dat !== e_dat)
            begin n_err++; $display("FAIL rnd src%0d data c%0d: got %0h want %0h", s + 1, c,
                                    got_dat, e_dat); end
        end
      end

      // Advance the model across the clock edge.
      if (flush) begin
        mq.delete();
        m_next = 1;
      end else begin
        cf = e_cv && cr;
        af = av && (mq.size() < 8) && !squash;
        kq = squash ? find_idx(sq_tag) : mq.size() - 1;
        for (int p = 0; p < 2; p++) begin
          k = find_idx(cpt[p]);
          if (cpv[p] && k >= 0 && k <= kq) begin
            mq[k].done = 1'b1;
            mq[k].exc  = cpx[p];
            mq[k].data = cpd[p];
          end
        end
        if (squash) begin
          while (mq.size() > kq + 1) void'(mq.pop_back());
          m_next = sq_tag % 8 + 1;
        end
        if (cf) void'(mq.pop_front());
        if (af) begin
          ent = '{tag: m_next, dest: adest, done: 1'b0, exc: 1'b0, data: 64'd0};
          mq.push_back(ent);
          m_next = m_next % 8 + 1;
        end
      end
      cycle();
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_alloc_four();
    test_complete_commit();
    test_bypass();
    test_flush();
    test_full_wrap();
    test_squash();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
